// File: rtl/step_seq_pkg.sv
// Shared defaults, FSM state encoding and length clamping for the drum-machine
// step sequencer.
package step_seq_pkg;

    localparam int DEF_N_CH    = 4;
    localparam int DEF_N_STEPS = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } seq_state_e;

    // A length of zero, or one beyond the grid, selects the full grid.
    function automatic int clamp_len(input int len, input int n_steps);
        if ((len == 0) || (len > n_steps)) begin
            return n_steps;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_pattern_mem.sv
// N_CH x N_STEPS on/off grid: whole-row write port, combinational column read
// by step index.
module seq_pattern_mem
    import step_seq_pkg::*;
#(
    parameter  int N_CH    = DEF_N_CH,
    parameter  int N_STEPS = DEF_N_STEPS,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int STEP_W  = $clog2(N_STEPS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_wr_en,
    input  logic [CH_W-1:0]     i_wr_ch,
    input  logic [N_STEPS-1:0]  i_wr_pattern,
    input  logic [STEP_W-1:0]   i_rd_step,
    output logic [N_CH-1:0]     o_rd_col
);

    logic [N_STEPS-1:0] r_rows [N_CH];
    logic               w_wr_valid;

    // Channel codes beyond N_CH exist when N_CH is not a power of two.
    assign w_wr_valid = i_wr_en && (int'(i_wr_ch) < N_CH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                r_rows[c] <= '0;
            end
        end else if (w_wr_valid) begin
            r_rows[i_wr_ch] <= i_wr_pattern;
        end
    end

    always_comb begin
        o_rd_col = '0;
        for (int c = 0; c < N_CH; c++) begin
            o_rd_col[c] = r_rows[c][i_rd_step];
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Pattern sequencer top: IDLE/PLAY FSM, step counter with latched bar length,
// and registered per-channel trigger and bar-wrap pulses.
module step_sequencer
    import step_seq_pkg::*;
#(
    parameter  int N_CH    = DEF_N_CH,
    parameter  int N_STEPS = DEF_N_STEPS,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int STEP_W  = $clog2(N_STEPS),
    localparam int LEN_W   = $clog2(N_STEPS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step_tick,
    input  logic                start,
    input  logic                stop,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [N_STEPS-1:0]  wr_pattern,
    input  logic [N_CH-1:0]     mute,
    input  logic [LEN_W-1:0]    length,
    output logic [N_CH-1:0]     trig,
    output logic [STEP_W-1:0]   step,
    output logic                playing,
    output logic                bar_pulse
);

    seq_state_e           r_state;
    logic [STEP_W-1:0]    r_step;
    logic [LEN_W-1:0]     r_len;
    logic [N_CH-1:0]      r_trig;
    logic                 r_bar;
    logic                 r_playing;

    logic [LEN_W-1:0]     w_len_clamped;
    logic [STEP_W-1:0]    w_next_step;
    logic [STEP_W-1:0]    w_rd_step;
    logic [N_CH-1:0]      w_mem_col;
    logic [N_CH-1:0]      w_col;
    logic                 w_rd_is_zero;

    assign w_len_clamped = LEN_W'(clamp_len(int'(length), N_STEPS));

    always_comb begin
        w_next_step = r_step + 1'b1;
        if ((int'(r_step) + 1) >= int'(r_len)) begin
            w_next_step = '0;
        end
    end

    // The column is read for the step being entered; a start always enters 0.
    assign w_rd_step    = start ? '0 : w_next_step;
    assign w_rd_is_zero = (w_rd_step == '0);
    assign w_col        = w_mem_col & ~mute;

    seq_pattern_mem #(
        .N_CH    (N_CH),
        .N_STEPS (N_STEPS)
    ) u_mem (
        .clk          (clk),
        .reset        (reset),
        .i_wr_en      (wr_en),
        .i_wr_ch      (wr_ch),
        .i_wr_pattern (wr_pattern),
        .i_rd_step    (w_rd_step),
        .o_rd_col     (w_mem_col)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_step    <= '0;
            r_len     <= LEN_W'(N_STEPS);
            r_trig    <= '0;
            r_bar     <= 1'b0;
            r_playing <= 1'b0;
        end else begin
            r_trig <= '0;
            r_bar  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        r_state   <= ST_PLAY;
                        r_playing <= 1'b1;
                        r_step    <= '0;
                        r_len     <= w_len_clamped;
                        r_trig    <= w_col;
                        r_bar     <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        r_state   <= ST_IDLE;
                        r_playing <= 1'b0;
                        r_step    <= '0;
                    end else if (start) begin
                        r_step <= '0;
                        r_len  <= w_len_clamped;
                        r_trig <= w_col;
                        r_bar  <= 1'b1;
                    end else if (step_tick) begin
                        r_step <= w_next_step;
                        r_trig <= w_col;
                        r_bar  <= w_rd_is_zero;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_playing <= 1'b0;
                    r_step    <= '0;
                end
            endcase
        end
    end

    assign trig      = r_trig;
    assign step      = r_step;
    assign playing   = r_playing;
    assign bar_pulse = r_bar;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: a vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_step_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       step_tick, start, stop, wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_pattern;
    logic [3:0] mute;
    logic [3:0] length;

    logic [3:0] trig;
    logic [2:0] step;
    logic       playing, bar_pulse;

    logic [2:0] trig3;
    logic [2:0] step3;
    logic       playing3, bar3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    step_sequencer u_dut (
        .clk(clk), .reset(reset), .step_tick(step_tick), .start(start), .stop(stop),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_pattern(wr_pattern), .mute(mute), .length(length),
        .trig(trig), .step(step), .playing(playing), .bar_pulse(bar_pulse)
    );

    step_sequencer #(.N_CH(3)) u_dut3 (
        .clk(clk), .reset(reset), .step_tick(step_tick), .start(start), .stop(stop),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_pattern(wr_pattern), .mute(mute[2:0]), .length(length),
        .trig(trig3), .step(step3), .playing(playing3), .bar_pulse(bar3)
    );

    // Behavioural model: grid as plain arrays, step advances modulo bar length.
    logic [7:0] m_pat [4];
    bit         m_play;
    int         m_step;
    int         m_len;
    logic [3:0] m_trig;
    bit         m_bar;

    task automatic model_reset();
        for (int c = 0; c < 4; c++) m_pat[c] = 8'h00;
        m_play = 0;
        m_step = 0;
        m_len  = 8;
        m_trig = 4'h0;
        m_bar  = 0;
    endtask

    task automatic model_fire();
        for (int c = 0; c < 4; c++) m_trig[c] = m_pat[c][m_step] & ~mute[c];
        m_bar = (m_step == 0);
    endtask

    task automatic model_step();
        m_trig = 4'h0;
        m_bar  = 0;
        if (m_play && stop) begin
            m_play = 0;
            m_step = 0;
        end else if (start && !stop) begin
            m_len  = (length == 0 || length > 8) ? 8 : int'(length);
            m_play = 1;
            m_step = 0;
            model_fire();
        end else if (m_play && step_tick) begin
            m_step = (m_step + 1) % m_len;
            model_fire();
        end
        if (wr_en) m_pat[wr_ch] = wr_pattern;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_pulses();
        start = 0; stop = 0; step_tick = 0; wr_en = 0;
    endtask

    // One clock: model decides from the inputs now applied, then DUTs compared.
    task automatic do_cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("trig",      32'(trig),      32'(m_trig));
        chk("step",      32'(step),      32'(m_step));
        chk("playing",   32'(playing),   32'(m_play));
        chk("bar_pulse", 32'(bar_pulse), 32'(m_bar));
        chk("trig_n3",   32'(trig3),     32'(m_trig[2:0]));
        chk("step_n3",   32'(step3),     32'(m_step));
        chk("playing_n3",32'(playing3),  32'(m_play));
        chk("bar_n3",    32'(bar3),      32'(m_bar));
        clear_pulses();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            step_tick = 1;
            do_cycle();
        end
    endtask

    typedef struct {
        bit         st, sp, tk, we;
        logic [1:0] ch;
        logic [7:0] pat;
        logic [3:0] exp_trig;
        int         exp_step;
        bit         exp_play, exp_bar;
    } vec_t;

    vec_t vecs[12];

    initial begin
        reset = 1;
        clear_pulses();
        wr_ch = 0; wr_pattern = 0; mute = 0; length = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_trig", 32'(trig), 0);
        chk("rst_step", 32'(step), 0);
        chk("rst_play", 32'(playing), 0);
        chk("rst_bar",  32'(bar_pulse), 0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;

        // Test 1: basic 8-step bar via table
        vecs[0]  = '{0,0,0,1, 2'd0, 8'h11, 4'b0000, 0, 0, 0};
        vecs[1]  = '{0,0,0,1, 2'd1, 8'h44, 4'b0000, 0, 0, 0};
        vecs[2]  = '{1,0,0,0, 2'd0, 8'h00, 4'b0001, 0, 1, 1};
        vecs[3]  = '{0,0,1,0, 2'd0, 8'h00, 4'b0000, 1, 1, 0};
        vecs[4]  = '{0,0,1,0, 2'd0, 8'h00, 4'b0010, 2, 1, 0};
        vecs[5]  = '{0,0,1,0, 2'd0, 8'h00, 4'b0000, 3, 1, 0};
        vecs[6]  = '{0,0,1,0, 2'd0, 8'h00, 4'b0001, 4, 1, 0};
        vecs[7]  = '{0,0,1,0, 2'd0, 8'h00, 4'b0000, 5, 1, 0};
        vecs[8]  = '{0,0,1,0, 2'd0, 8'h00, 4'b0010, 6, 1, 0};
        vecs[9]  = '{0,0,1,0, 2'd0, 8'h00, 4'b0000, 7, 1, 0};
        vecs[10] = '{0,0,1,0, 2'd0, 8'h00, 4'b0001, 0, 1, 1};
        vecs[11] = '{0,0,0,0, 2'd0, 8'h00, 4'b0000, 0, 1, 0};
        for (int v = 0; v < 12; v++) begin
            start = vecs[v].st; stop = vecs[v].sp; step_tick = vecs[v].tk;
            wr_en = vecs[v].we; wr_ch = vecs[v].ch; wr_pattern = vecs[v].pat;
            do_cycle();
            chk($sformatf("vec%0d_trig", v), 32'(trig),      32'(vecs[v].exp_trig));
            chk($sformatf("vec%0d_step", v), 32'(step),      32'(vecs[v].exp_step));
            chk($sformatf("vec%0d_play", v), 32'(playing),   32'(vecs[v].exp_play));
            chk($sformatf("vec%0d_bar", v),  32'(bar_pulse), 32'(vecs[v].exp_bar));
        end

        // Test 2: length 3, then mid-play length change ignored
        length = 3; start = 1; do_cycle();
        for (int i = 0; i < 6; i++) begin
            step_tick = 1; do_cycle();
            chk("len3_step", 32'(step), 32'((i + 1) % 3));
            chk("len3_bar",  32'(bar_pulse), 32'(((i + 1) % 3) == 0));
        end
        length = 5;
        for (int i = 0; i < 3; i++) begin
            step_tick = 1; do_cycle();
            chk("len_hold_step", 32'(step), 32'((i + 1) % 3));
        end

        // Test 3: mute is live, not latched
        stop = 1; do_cycle();
        wr_en = 1; wr_ch = 0; wr_pattern = 8'hFF; do_cycle();
        mute = 4'b0001; start = 1; do_cycle();
        chk("mute_start_trig0", 32'(trig[0]), 0);
        for (int i = 0; i < 4; i++) begin
            step_tick = 1; do_cycle();
            chk("mute_trig0", 32'(trig[0]), 0);
        end
        mute = 4'b0000; step_tick = 1; do_cycle();
        chk("unmute_trig0", 32'(trig[0]), 1);

        // Test 4: priority corners
        stop = 1; do_cycle();
        start = 1; stop = 1; do_cycle();
        chk("idle_ss_play", 32'(playing), 0);
        chk("idle_ss_trig", 32'(trig), 0);
        start = 1; do_cycle();
        tick_n(2);
        stop = 1; step_tick = 1; do_cycle();
        chk("stop_tick_play", 32'(playing), 0);
        chk("stop_tick_step", 32'(step), 0);
        chk("stop_tick_trig", 32'(trig), 0);
        start = 1; do_cycle();
        tick_n(2);
        start = 1; step_tick = 1; do_cycle();
        chk("restart_step", 32'(step), 0);
        chk("restart_trig", 32'(trig), 32'(4'b0001));
        chk("restart_bar",  32'(bar_pulse), 1);
        do_cycle();
        chk("restart_once", 32'(trig), 0);

        // Test 5: write colliding with tick uses old data; out-of-range channel on N_CH=3
        length = 0; start = 1; do_cycle();
        step_tick = 1; wr_en = 1; wr_ch = 3; wr_pattern = 8'h02; do_cycle();
        chk("wr_coll_old", 32'(trig[3]), 0);
        chk("wr_coll_n3",  32'(trig3), 32'(3'b001));
        tick_n(7);
        chk("wr_coll_wrap", 32'(step), 0);
        step_tick = 1; do_cycle();
        chk("wr_coll_new", 32'(trig[3]), 1);
        chk("wr_oor_n3",   32'(trig3), 32'(3'b001));

        // Test 6: asynchronous reset mid-play
        start = 1; do_cycle();
        chk("pre_rst_trig", 32'(trig), 32'(4'b0001));
        #2;
        reset = 1;
        #1;
        model_reset();
        chk("arst_trig", 32'(trig), 0);
        chk("arst_step", 32'(step), 0);
        chk("arst_play", 32'(playing), 0);
        chk("arst_bar",  32'(bar_pulse), 0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        tick_n(3);
        chk("post_rst_trig", 32'(trig), 0);
        start = 1; do_cycle();
        chk("post_rst_cleared", 32'(trig), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step_tick  = ($urandom_range(0, 2) != 0);
            start      = ($urandom_range(0, 19) == 0);
            stop       = ($urandom_range(0, 29) == 0);
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_ch      = 2'($urandom);
            wr_pattern = 8'($urandom);
            mute       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            length     = 4'($urandom_range(0, 15));
            do_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
Parametrised pattern sequencer for the drum machine, replacing the fixed 4-instrument x 8-step pattern store/timing logic. It holds an N_CH x N_STEPS on/off grid and advances one step per tempo tick from the bpm divider. Each step it emits one-cycle trigger pulses per channel to the sample players. New behaviour over the current datapath:
- run-time writable pattern length
- per-channel mute
- restart-on-start
- bar-wrap pulse
- step index output for VGA/HEX display

Parameters:
N_CH, 4, number of instrument channels (>=1)
N_STEPS, 8, maximum steps per bar (>=2)
CH_W, $clog2(N_CH) (min 1), channel index width (derived)
STEP_W, $clog2(N_STEPS), step index width (derived)
LEN_W, $clog2(N_STEPS+1), pattern-length width (derived)

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  asynchronous, active-high; clears all state
step_tick  in  1  one-cycle tempo pulse from bpm divider
start  in  1  one-cycle pulse: begin/restart playback at step 0
stop  in  1  one-cycle pulse: halt playback
wr_en  in  1  pattern write strobe
wr_ch  in  CH_W  channel to write
wr_pattern  in  N_STEPS  step bits for wr_ch; bit i = step i
mute  in  N_CH  per-channel mute, sampled live
length  in  LEN_W  active steps per bar; 0 or >N_STEPS means N_STEPS
trig  out  N_CH  registered one-cycle trigger per channel
step  out  STEP_W  current step index
playing  out  1  high in PLAY state
bar_pulse  out  1  one-cycle pulse when step 0 fires

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, step=0, trig=0, bar_pulse=0, playing=0
  - pattern memory all 0
  - latched length=N_STEPS
- FSM has two states, IDLE and PLAY.
- IDLE -> PLAY on start (stop low):
  - next cycle: step=0, trig=col(0), bar_pulse=1, playing=1
  - length latched this cycle
- PLAY + start (stop low): restart. Same response as IDLE->PLAY; length re-latched.
- PLAY + step_tick (no start/stop):
  - step <= (step==len_l-1) ? 0 : step+1
  - next cycle: trig=col(new step), bar_pulse=1 iff new step==0
- PLAY + stop -> IDLE:
  - next cycle: step=0, trig=0, bar_pulse=0, playing=0
- Priority when signals coincide: stop > start > step_tick.
  - step_tick coinciding with start or stop is dropped.
- step_tick in IDLE is ignored.
- col(s)[c] = pattern[c][s] & ~mute[c], using the pattern and mute values present in the cycle the step is decided.
  - A write in the same cycle as a tick affects only later steps (old data used).
- Latency: trig and bar_pulse appear exactly 1 cycle after the qualifying start/step_tick. They are high for exactly 1 cycle and are 0 in all other cycles.
- Writes:
  - Accepted in any state.
  - wr_ch >= N_CH is ignored (no change to any channel).
  - Write replaces the whole row.
- Length:
  - latched only on start; changing the length input mid-bar has no effect until the next start.
  - len_l=1 → step stays 0; every tick retriggers col(0) with bar_pulse.
- Mute is not latched; it affects only triggers decided while it is asserted.
- Reset mid-play: everything returns to reset values immediately, including pattern memory.

Decomposition:
- Package step_seq_pkg holds:
  - default N_CH/N_STEPS
  - FSM state encoding (ST_IDLE, ST_PLAY)
  - function to clamp length (0/overflow → N_STEPS)
- One sub-module, seq_pattern_mem:
  - N_CH x N_STEPS register file
  - row write port (wr_en/wr_ch/wr_pattern)
  - combinational column read by step index
- FSM, step counter and trigger registers stay in step_sequencer.

Test Plan:
1. Reset, write ch0=8'b0001_0001, ch1=8'b0100_0100, start, 8 ticks → trig 4'b0001 at steps 0,4; trig 4'b0010 at steps 2,6; bar_pulse only at step 0; step wraps 7→0 on 8th tick with trig 4'b0001 and bar_pulse.
2. length=3, start, 6 ticks → step sequence 0,1,2,0,1,2,0; bar_pulse at each 0. Change length to 5 mid-play → sequence unchanged until next start.
3. mute=4'b0001 with ch0 all ones, ticks → trig[0] never asserts. Clear mute → trig[0] on the next tick.
4. start and stop in same cycle while IDLE → stays IDLE, trig=0. stop with tick in PLAY → IDLE, step=0, no trig. start with tick in PLAY → step=0, single col(0) trigger.
5. wr_en with wr_ch=N_CH-1 setting step 1 in the same cycle as the tick reaching step 1 → no trig that pass, trig on the next bar. wr_ch out of range (N_CH=3 build, wr_ch=3) → pattern unchanged.
6. Assert reset asynchronously between clock edges mid-play → trig/step/playing/bar_pulse drop to 0 at once. After release, ticks give no trig until start.
